// File: rtl/prbs31_checker_if.sv
// rtl/prbs31_checker_if.sv - stream and status bundle for the PRBS31 checker
//
// Purpose: groups the received byte stream, the counter clear and the
// checker status outputs so the receive path connects with one port.
//
// Signals:
//   din        [7:0]       received byte, din[7] earliest bit in time
//   din_valid              din qualifies this cycle
//   clr_cnt                synchronous clear of err_count
//   locked                 checker is in LOCKED
//   err_pulse              compared byte had at least one bit error
//   err_bits   [3:0]       popcount of the compared byte's errors
//   err_count  [ERR_W-1:0] saturating total of err_bits
//   state      [1:0]       00 HUNT, 01 SYNC, 10 LOCKED
//
// Modports: master drives the stream, slave is the checker.

interface prbs31_checker_if #(
  parameter int ERR_W = 16
) ();

  logic [7:0]       din;
  logic             din_valid;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [3:0]       err_bits;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state;

  modport master (
    output din,
    output din_valid,
    output clr_cnt,
    input  locked,
    input  err_pulse,
    input  err_bits,
    input  err_count,
    input  state
  );

  modport slave (
    input  din,
    input  din_valid,
    input  clr_cnt,
    output locked,
    output err_pulse,
    output err_bits,
    output err_count,
    output state
  );

endinterface

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - byte-wide PRBS31 (x^31 + x^28 + 1) receive checker
//
// Purpose: self-synchronises a 31-bit history to the received byte stream,
// then free-runs a local PRBS31 sequence and reports per-byte bit errors and
// a saturating error total.
//
// Parameters:
//   LOCK_CNT  consecutive error-free bytes in SYNC needed to lock (1..255)
//   LOSS_CNT  consecutive errored bytes in LOCKED that drop to HUNT (1..15)
//   ERR_W     width of the saturating error counter (>= 4)
//
// Ports:
//   clk    clock, all state on rising edge
//   rst_n  asynchronous reset, active HIGH (1 = reset)
//   bus    prbs31_checker_if.slave: din/din_valid/clr_cnt in,
//          locked/err_pulse/err_bits/err_count/state out

module prbs31_checker #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  prbs31_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  // hist[0] is the most recent bit, hist[30] the oldest, so the taps for
  // b[n] = b[n-31] ^ b[n-28] sit at hist[30] and hist[27].
  state_t           state_q,     state_d;
  logic [30:0]      hist_q,      hist_d;
  logic [1:0]       hunt_cnt_q,  hunt_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       loss_cnt_q,  loss_cnt_d;
  logic             locked_q,    locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [3:0]       err_bits_q,  err_bits_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [30:0]      walk;
  logic [7:0]       pred;
  logic [7:0]       diff;
  logic [3:0]       diff_cnt;
  logic [ERR_W-1:0] count_base;
  logic [ERR_W:0]   count_sum;
  logic [ERR_W-1:0] count_sat;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Eight successive applications of the sequence rule, earliest bit into
  // pred[7]. The walking copy is discarded: the shifted history is simply
  // {hist[22:0], byte}.
  always_comb begin
    walk = hist_q;
    pred = '0;
    for (int i = 7; i >= 0; i--) begin
      pred[i] = walk[30] ^ walk[27];
      walk    = {walk[29:0], pred[i]};
    end
  end

  assign diff     = bus.din ^ pred;
  assign diff_cnt = popcount8(diff);

  // Clear happens before the add so a clear on an errored byte leaves
  // exactly that byte's error count.
  assign count_base = bus.clr_cnt ? '0 : err_count_q;
  assign count_sum  = {1'b0, count_base} + {{(ERR_W - 3){1'b0}}, diff_cnt};
  assign count_sat  = count_sum[ERR_W] ? {ERR_W{1'b1}} : count_sum[ERR_W-1:0];

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    hunt_cnt_d  = hunt_cnt_q;
    match_cnt_d = match_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    err_pulse_d = 1'b0;
    err_bits_d  = err_bits_q;
    err_count_d = bus.clr_cnt ? '0 : err_count_q;

    if (bus.din_valid) begin
      unique case (state_q)
        HUNT: begin
          hist_d = {hist_q[22:0], bus.din};
          if (hunt_cnt_q == 2'd3) begin
            state_d     = SYNC;
            hunt_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            hunt_cnt_d = hunt_cnt_q + 2'd1;
          end
        end

        SYNC: begin
          // Received data, not the prediction, trains the history here.
          hist_d = {hist_q[22:0], bus.din};
          if (diff != 8'h00) begin
            match_cnt_d = '0;
          end else if (hist_q == '0) begin
            // The all-zero lockup state predicts zeros forever; never
            // let it count towards lock.
            match_cnt_d = '0;
          end else if (match_cnt_q == 8'(LOCK_CNT - 1)) begin
            state_d     = LOCKED;
            match_cnt_d = '0;
            loss_cnt_d  = '0;
          end else begin
            match_cnt_d = match_cnt_q + 8'd1;
          end
        end

        LOCKED: begin
          // Free-run on the prediction so a single flipped input bit
          // cannot propagate into later predictions.
          hist_d      = {hist_q[22:0], pred};
          err_bits_d  = diff_cnt;
          err_pulse_d = (diff != 8'h00);
          err_count_d = count_sat;
          if (diff != 8'h00) begin
            if (loss_cnt_q == 4'(LOSS_CNT - 1)) begin
              state_d     = HUNT;
              hist_d      = '0;
              hunt_cnt_d  = '0;
              match_cnt_d = '0;
              loss_cnt_d  = '0;
            end else begin
              loss_cnt_d = loss_cnt_q + 4'd1;
            end
          end else begin
            loss_cnt_d = '0;
          end
        end

        default: begin
          state_d     = HUNT;
          hist_d      = '0;
          hunt_cnt_d  = '0;
          match_cnt_d = '0;
          loss_cnt_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= HUNT;
      hist_q      <= '0;
      hunt_cnt_q  <= '0;
      match_cnt_q <= '0;
      loss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_bits_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      hunt_cnt_q  <= hunt_cnt_d;
      match_cnt_q <= match_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_bits_q  <= err_bits_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_bits  = err_bits_q;
  assign bus.err_count = err_count_q;

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side companion to the team's byte-wide PRBS31 generator (polynomial x^31 + x^28 + 1, 8 bits per clock).
- Self-synchronises its 31-bit history to the incoming byte stream.
- Once locked, free-runs a local PRBS31 sequence, compares it bit-by-bit against received data, and reports per-byte bit errors plus a saturating error count.
- Sits on the receive path of the loopback/BERT test datapath and feeds status to the I/O wrapper.

Parameters:
- LOCK_CNT, 8, consecutive error-free bytes required in SYNC to declare lock (1..255).
- LOSS_CNT, 4, consecutive errored bytes in LOCKED that force a return to HUNT (1..15).
- ERR_W, 16, width of the saturating bit-error counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-high. Despite the name, 1 = reset.
- din  input  8  received byte; din[7] is the earliest bit in time.
- din_valid  input  1  din qualifies this cycle; invalid cycles do not advance any state.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle strobe; compared byte had at least one bit error.
- err_bits  output  4  popcount of the compared byte's errors (0..8).
- err_count  output  ERR_W  saturating total of err_bits since reset/clear.
- state  output  2  00 HUNT, 01 SYNC, 10 LOCKED.

Behaviour:
- Sequence definition: bit stream b[n] = b[n-31] ^ b[n-28]. hist holds the last 31 bits.
- Prediction: next byte = 8 successive applications of the sequence rule, MSB first. Computed combinationally from hist in one cycle.
- Reset values: state = HUNT, hist = 0, byte counters = 0, locked = 0, err_pulse = 0, err_bits = 0, err_count = 0.
- All outputs are registered. Results for a byte accepted at edge k appear after edge k and hold until the next valid byte.
- err_pulse drops to 0 on any cycle without din_valid.
- HUNT:
  - Each valid byte shifts din into hist.
  - After 4 valid bytes (32 bits, hist fully loaded) go to SYNC with match_cnt = 0.
  - err_* outputs are not updated in HUNT.
- SYNC:
  - Compare din against the prediction from hist, then shift din (received data, not prediction) into hist.
  - Match with hist != 0: increment match_cnt.
  - Match with hist == 0: match_cnt = 0. The all-zero lockup state never produces a lock.
  - Mismatch: match_cnt = 0, stay in SYNC.
  - match_cnt reaching LOCK_CNT: go to LOCKED on that edge.
  - No error counting in SYNC.
- LOCKED:
  - hist is updated with the predicted byte (free-running), not din, so one flipped bit yields exactly one error.
  - err_bits = popcount(din ^ pred).
  - err_pulse = (err_bits != 0).
  - err_count += err_bits, saturating at 2^ERR_W - 1 with no wrap.
  - Errored byte increments loss_cnt; clean byte clears it.
  - loss_cnt reaching LOSS_CNT: go to HUNT, clear hist and counters. err_count is retained.
- clr_cnt:
  - err_count := 0 that cycle.
  - If clr_cnt coincides with an errored byte, the result is err_bits of that byte (clear then add).
- Reset mid-operation: immediate return to reset values regardless of state.
- din_valid low for any number of cycles: no state, counter or hist change.

Test Plan:
- Generator seeded all-ones (first bytes 00 00 00 0E ...), continuous valid, defaults -> state HUNT 4 bytes, SYNC 8 bytes, locked rises after the 12th valid byte edge; err_count stays 0 over 10,000 bytes.
- Locked stream, flip bit 0 of one byte -> exactly one err_pulse, err_bits = 1, err_count = 1; following bytes error-free (no multiplication); locked stays 1.
- Locked, then 4 consecutive bytes inverted (0xFF xor) -> err_bits = 8 each, err_count = 32, state HUNT after the 4th; relocks after 12 more good bytes; err_count still 32.
- All-zero input for 100 bytes -> never leaves SYNC, locked = 0, err_count = 0.
- ERR_W = 4, locked, inject 3 fully inverted bytes -> err_count saturates at 15 (not 8); clr_cnt together with a byte having 2 errors -> err_count = 2.
- Random din_valid gaps (50% duty) on a clean stream -> same lock timing in valid-byte terms, zero errors. Assert rst_n mid-LOCKED -> all outputs 0 and state HUNT on the following cycle.
